// File: rtl/u_xmit_fifo_if.sv
// Write handshake between the host register block and the UART transmit FIFO.
interface u_xmit_fifo_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              xmit_validH;
   logic              xmit_readyH;
   logic [DATA_W-1:0] xmit_dataH;

   modport master (output xmit_validH, output xmit_dataH, input xmit_readyH);
   modport slave  (input xmit_validH, input xmit_dataH, output xmit_readyH);
endinterface

// File: rtl/u_xmit_fifo.sv
// Parametrised UART transmitter with a small TX FIFO and per-frame parity/stop config.
module u_xmit_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned OVS        = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_l,
   u_xmit_fifo_if.slave     wr,
   input  logic [1:0]       parity_modeH,
   input  logic             two_stopH,
   output logic             uart_xmitH,
   output logic             xmit_busyH,
   output logic             xmit_doneH,
   output logic [CNT_W-1:0] fifo_countH
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CELL_W = (OVS > 1) ? $clog2(OVS) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // FIFO storage and pointers
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ready_q, ready_d;

   // Transmit engine
   logic [2:0]        state_q, state_d;
   logic [CELL_W-1:0] cell_q, cell_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              par_en_q, par_en_d;
   logic              two_stop_q, two_stop_d;
   logic              line_q, line_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              push_c;
   logic              pop_c;
   logic              cell_end_c;
   logic [DATA_W-1:0] head_c;

   assign push_c     = wr.xmit_validH & ready_q;
   assign head_c     = mem_q[rd_ptr_q];
   assign cell_end_c = (cell_q == CELL_W'(OVS - 1));

   // FIFO pointer, fill level and ready computation
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ready_d = (count_d != CNT_W'(FIFO_DEPTH));
   end

   // FIFO data array; contents are don't-care until written
   always_ff @(posedge sys_clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr.xmit_dataH;
      end
   end

   // Next-state, shift and line computation for the frame engine
   always_comb begin
      state_d    = state_q;
      cell_d     = cell_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      line_d     = 1'b1;
      done_d     = 1'b0;
      pop_c      = 1'b0;

      case (state_q)
         S_IDLE: begin
            cell_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop_c = 1'b1;
            end
         end
         S_START: begin
            line_d = 1'b0;
            cell_d = cell_end_c ? '0 : cell_q + CELL_W'(1);
            if (cell_end_c) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            line_d = shreg_q[0];
            cell_d = cell_end_c ? '0 : cell_q + CELL_W'(1);
            if (cell_end_c) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            line_d = par_q;
            cell_d = cell_end_c ? '0 : cell_q + CELL_W'(1);
            if (cell_end_c) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            line_d = 1'b1;
            cell_d = cell_end_c ? '0 : cell_q + CELL_W'(1);
            if (cell_end_c) begin
               // bit_q counts completed stop cells when two stop bits are selected
               if (two_stop_q && (bit_q == '0)) begin
                  bit_d = BIT_W'(1);
               end else begin
                  bit_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  if (count_q != '0) begin
                     pop_c = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            line_d  = 1'b1;
            cell_d  = '0;
            bit_d   = '0;
         end
      endcase

      // A pop starts a frame: load the word and freeze this frame's config
      if (pop_c) begin
         shreg_d    = head_c;
         par_en_d   = (parity_modeH != 2'b00);
         two_stop_d = two_stopH;
         case (parity_modeH)
            2'b01:   par_d = ^head_c;
            2'b10:   par_d = ~^head_c;
            default: par_d = 1'b1;
         endcase
         state_d = S_START;
         cell_d  = '0;
         bit_d   = '0;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset drops the frame and empties the FIFO
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_q    <= 1'b1;
         state_q    <= S_IDLE;
         cell_q     <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         line_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         state_q    <= state_d;
         cell_q     <= cell_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         line_q     <= line_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign wr.xmit_readyH = ready_q;
   assign uart_xmitH     = line_q;
   assign xmit_busyH     = busy_q;
   assign xmit_doneH     = done_q;
   assign fifo_countH    = count_q;

endmodule

// File: tb/tb_u_xmit_fifo.sv
// Bench for u_xmit_fifo: two instances (8/16 and 7/4) against a frame-level model.
module tb_u_xmit_fifo;

   localparam int DEPTH = 4;
   localparam int A_DW = 8, A_OVS = 16;
   localparam int B_DW = 7, B_OVS = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       two_stop = 1'b0;

   u_xmit_fifo_if #(.DATA_W(A_DW)) ifa ();
   u_xmit_fifo_if #(.DATA_W(B_DW)) ifb ();

   logic       a_line, a_busy, a_done;
   logic [2:0] a_cnt;
   logic       b_line, b_busy, b_done;
   logic [2:0] b_cnt;

   u_xmit_fifo #(.DATA_W(A_DW), .OVS(A_OVS), .FIFO_DEPTH(DEPTH)) dut_a (
      .sys_clk(clk), .sys_rst_l(rst_n), .wr(ifa.slave),
      .parity_modeH(mode), .two_stopH(two_stop),
      .uart_xmitH(a_line), .xmit_busyH(a_busy), .xmit_doneH(a_done), .fifo_countH(a_cnt));

   u_xmit_fifo #(.DATA_W(B_DW), .OVS(B_OVS), .FIFO_DEPTH(DEPTH)) dut_b (
      .sys_clk(clk), .sys_rst_l(rst_n), .wr(ifb.slave),
      .parity_modeH(mode), .two_stopH(two_stop),
      .uart_xmitH(b_line), .xmit_busyH(b_busy), .xmit_doneH(b_done), .fifo_countH(b_cnt));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic get_line(input int k);
      return (k == 0) ? a_line : b_line;
   endfunction
   function automatic logic get_done(input int k);
      return (k == 0) ? a_done : b_done;
   endfunction
   function automatic logic get_rdy(input int k);
      return (k == 0) ? ifa.xmit_readyH : ifb.xmit_readyH;
   endfunction
   function automatic int ovs_of(input int k);
      return (k == 0) ? A_OVS : B_OVS;
   endfunction
   function automatic int dw_of(input int k);
      return (k == 0) ? A_DW : B_DW;
   endfunction

   // Frame-level model: FIFO as an ordered list, frame as a list of bit cells
   logic [8:0]  mf [2][DEPTH];
   int          mcnt [2] = '{0, 0};
   bit          inf [2] = '{0, 0};
   bit          mdone [2] = '{0, 0};
   int          ph [2] = '{0, 0};
   int          flen [2] = '{0, 0};
   logic [15:0] mcells [2];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
               mcnt[k] = 0; inf[k] = 0; mdone[k] = 0; ph[k] = 0;
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               bit         acc;
               logic [8:0] hd;
               logic [8:0] din;
               logic       pv;
               int         nc;
               acc = ((k == 0) ? ifa.xmit_validH : ifb.xmit_validH) && (mcnt[k] != DEPTH);
               din = (k == 0) ? 9'(ifa.xmit_dataH) : 9'(ifb.xmit_dataH);
               mdone[k] = 0;
               if (inf[k]) begin
                  ph[k]++;
                  if (ph[k] == flen[k]) begin
                     inf[k] = 0;
                     mdone[k] = 1;
                  end
               end
               if (!inf[k] && mcnt[k] != 0) begin
                  hd = mf[k][0];
                  for (int j = 0; j < DEPTH - 1; j++) mf[k][j] = mf[k][j+1];
                  mcnt[k]--;
                  mcells[k] = '0;
                  nc = 1;
                  pv = 1'b0;
                  for (int j = 0; j < dw_of(k); j++) begin
                     mcells[k][nc] = hd[j];
                     pv = pv ^ hd[j];
                     nc++;
                  end
                  if (mode != 2'b00) begin
                     mcells[k][nc] = (mode == 2'b01) ? pv : (mode == 2'b10) ? ~pv : 1'b1;
                     nc++;
                  end
                  mcells[k][nc] = 1'b1; nc++;
                  if (two_stop) begin
                     mcells[k][nc] = 1'b1; nc++;
                  end
                  flen[k] = nc * ovs_of(k);
                  ph[k] = 0;
                  inf[k] = 1;
               end
               if (acc) begin
                  mf[k][mcnt[k]] = din;
                  mcnt[k]++;
               end
            end
         end
      end
   end

   // Cycle compare of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               logic el;
               el = (inf[k] && ph[k] >= 1) ? mcells[k][(ph[k] - 1) / ovs_of(k)] : 1'b1;
               check((k == 0) ? "a_line" : "b_line", int'(get_line(k)), int'(el));
               check((k == 0) ? "a_busy" : "b_busy", int'((k == 0) ? a_busy : b_busy), int'(inf[k]));
               check((k == 0) ? "a_done" : "b_done", int'(get_done(k)), int'(mdone[k]));
               check((k == 0) ? "a_count" : "b_count", int'((k == 0) ? a_cnt : b_cnt), mcnt[k]);
               check((k == 0) ? "a_ready" : "b_ready", int'(get_rdy(k)), int'(mcnt[k] != DEPTH));
            end
         end
      end
   end

   task automatic push(input int k, input logic [8:0] d);
      int g;
      bit acc;
      g = 0;
      if (k == 0) begin ifa.xmit_validH = 1'b1; ifa.xmit_dataH = d[7:0]; end
      else        begin ifb.xmit_validH = 1'b1; ifb.xmit_dataH = d[6:0]; end
      do begin
         @(negedge clk);
         acc = get_rdy(k);
         @(posedge clk);
         #2;
         g++;
      end while (!acc && g < 5000);
      if (k == 0) ifa.xmit_validH = 1'b0;
      else        ifb.xmit_validH = 1'b0;
      if (!acc) check("push_timeout", 0, 1);
   endtask

   // Length from first low through the done cycle, and mid-cell samples of the line
   task automatic measure(input int k, output int len, output logic [15:0] cv);
      int g, n, o;
      o = ovs_of(k);
      len = 0;
      cv = '0;
      g = 0;
      do begin @(negedge clk); g++; end while (get_line(k) != 1'b0 && g < 2000);
      if (g >= 2000) begin
         check("start_timeout", 0, 1);
         return;
      end
      n = 0;
      forever begin
         if (n % o == o / 2) cv[n / o] = get_line(k);
         n++;
         if (get_done(k)) break;
         if (n > 1000) begin
            check("done_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      len = n;
   endtask

   task automatic wait_idle(input int k);
      int g;
      g = 0;
      while (g < 4000 && (((k == 0) ? (a_busy || a_cnt != 0) : (b_busy || b_cnt != 0)))) begin
         @(posedge clk);
         g++;
      end
      #2;
      if (g >= 4000) check("idle_timeout", 0, 1);
   endtask

   initial begin
      int          len;
      logic [15:0] cv;
      logic [7:0]  pex [3];
      ifa.xmit_validH = 1'b0; ifa.xmit_dataH = '0;
      ifb.xmit_validH = 1'b0; ifb.xmit_dataH = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_line", int'(a_line), 1);
      check("rst_ready", int'(ifa.xmit_readyH), 1);
      check("rst_busy", int'(a_busy), 0);
      check("rst_count", int'(a_cnt), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // 8N1 frame of 0xA5
      mode = 2'b00; two_stop = 1'b0;
      push(0, 9'h0A5);
      measure(0, len, cv);
      check("t1_len", len, 160);
      check("t1_cells", int'(cv[9:0]), 'h34A);
      wait_idle(0);

      // parity even / odd / mark on 0x07
      pex[0] = 8'd1; pex[1] = 8'd0; pex[2] = 8'd1;
      for (int m = 1; m <= 3; m++) begin
         mode = 2'(m);
         push(0, 9'h007);
         measure(0, len, cv);
         check("t2_len", len, 176);
         check("t2_data", int'(cv[8:1]), 'h07);
         check("t2_parity", int'(cv[9]), int'(pex[m-1]));
         wait_idle(0);
      end

      // 7-bit, OVS 4, two stop bits
      mode = 2'b00; two_stop = 1'b1;
      push(1, 9'h055);
      measure(1, len, cv);
      check("t3_len", len, 40);
      check("t3_cells", int'(cv[9:0]), int'({2'b11, 7'h55, 1'b0}));
      wait_idle(1);

      // five back-to-back pushes, then a sixth held off until a pop
      two_stop = 1'b0;
      for (int i = 0; i < 5; i++) push(0, 9'(8'h30 + i));
      @(negedge clk);
      check("t4_full_count", int'(a_cnt), 4);
      check("t4_full_ready", int'(ifa.xmit_readyH), 0);
      @(posedge clk); #2;
      push(0, 9'h0EE);
      wait_idle(0);

      // config change mid-frame only affects the next frame
      mode = 2'b00; two_stop = 1'b0;
      push(0, 9'h011);
      push(0, 9'h03C);
      fork
         measure(0, len, cv);
         begin
            repeat (40) @(posedge clk);
            #2;
            mode = 2'b10;
            two_stop = 1'b1;
         end
      join
      check("t5_len1", len, 160);
      measure(0, len, cv);
      check("t5_len2", len, 192);
      check("t5_parity2", int'(cv[9]), 1);
      wait_idle(0);

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         ifa.xmit_validH = ($urandom_range(0, 7) == 0);
         ifa.xmit_dataH  = 8'($urandom);
         ifb.xmit_validH = ($urandom_range(0, 5) == 0);
         ifb.xmit_dataH  = 7'($urandom);
         mode            = 2'($urandom);
         two_stop        = 1'($urandom);
         @(posedge clk);
         #2;
      end
      ifa.xmit_validH = 1'b0;
      ifb.xmit_validH = 1'b0;
      wait_idle(0);
      wait_idle(1);

      // reset during DATA with words queued
      mode = 2'b00; two_stop = 1'b0;
      push(0, 9'h0F0);
      push(0, 9'h00F);
      push(0, 9'h0AA);
      repeat (60) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_line", int'(a_line), 1);
      check("t6_count", int'(a_cnt), 0);
      check("t6_ready", int'(ifa.xmit_readyH), 1);
      check("t6_busy", int'(a_busy), 0);
      check("t6_done", int'(a_done), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (200) @(posedge clk);
      #2;
      check("t6_idle_line", int'(a_line), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
